checkin_tx: RTL and testbench
=============================

Name: checkin_tx

Overview:
- Transmit side of the check-in/pickup byte stream.
- Collects passenger/item bytes through a load port into a local circular buffer.
- On `start`, performs the `ready` handshake toward the queueing FIFO, streams the buffered bytes one per cycle, and terminates the stream with `'$'` (8'd36).
- Waits for the FIFO's `done`, then reports completion and clears itself for the next batch.

Parameters:
- DATA_LEN, 8, byte width of the stream.
- DEPTH, 16, buffer entries; must not exceed downstream FIFO tmp_len.
- CNT_W, 5, counter width; must satisfy $clog2(DEPTH+1) <= CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (rst==0 resets).
- load_valid  in  1  load byte presented.
- load_data  in  DATA_LEN  byte to buffer.
- load_ready  out  1  buffer accepts load this cycle.
- start  in  1  begin transmission (sampled only in IDLE).
- busy  out  1  high in every state except IDLE.
- ready  out  1  one-cycle handshake to downstream FIFO.
- tx_data  out  DATA_LEN  stream byte to downstream FIFO `in`.
- dn_done  in  1  downstream FIFO `done`.
- done  out  1  one-cycle completion pulse.
- letter_cnt  out  CNT_W  number of buffered bytes > 8'd64 (letters the FIFO will keep).

Behaviour:
- Reset (rst==0, asynchronous):
  - state=IDLE, pointers and count = 0.
  - load_ready=1, ready=0, tx_data=0, done=0, busy=0, letter_cnt=0.
  - Applies at any point mid-operation; the buffer contents are discarded.
- All outputs are registered or decoded from registered state; no input-to-output combinational path.
- Load (IDLE only):
  - load_ready = (state==IDLE) && (count<DEPTH).
  - A byte is accepted when load_valid && load_ready.
  - 8'd36 is never stored. It is dropped silently, and count and letter_cnt are unchanged.
  - Accepted byte > 8'd64 increments letter_cnt.
  - load_valid while full or busy: ignored, nothing stored.
- States:
  - IDLE:
    - ready=0, tx_data=0.
    - start=1 -> RDY. start has priority over a simultaneous load; that load byte is not taken.
  - RDY (exactly 1 cycle):
    - ready=1, tx_data=0.
    - -> SEND if count>0, else -> TERM.
  - SEND:
    - tx_data = buf[rd_ptr], one byte per cycle.
    - rd_ptr wraps at DEPTH-1 -> 0; count decrements each cycle.
    - When the last byte is on the bus -> TERM.
    - First SEND cycle is the cycle immediately after ready=1, because the FIFO samples `in` from its read state onward.
  - TERM (1 cycle):
    - tx_data=8'd36.
    - -> WAIT.
  - WAIT:
    - tx_data=0.
    - Holds until dn_done=1 -> FIN.
    - No timeout.
  - FIN (1 cycle):
    - done=1.
    - Clears pointers, count and letter_cnt.
    - -> IDLE.
- start outside IDLE is ignored.
- Latency:
  - start edge to ready: 1 cycle.
  - ready to '$': N+1 cycles for N buffered bytes.
- Empty buffer + start: stream is RDY then '$'. done follows dn_done.
- Full buffer (DEPTH bytes): all DEPTH bytes are sent in order; wrap-around of wr_ptr/rd_ptr must preserve order.
- Ordering: bytes leave in load order (FIFO).

Optional Feature:
- Macro CHECKIN_TX_SEP_EN.
- Defined:
  - After every transmitted letter byte except the last buffered byte, insert one separator cycle with tx_data=8'd35 ('#', <=64, so the FIFO discards it).
  - SEND duration becomes N + (number of letters not in last position).
  - The downstream FIFO result is unchanged.
- Undefined: no separator cycles; timing exactly as above.

Decomposition:
- Package checkin_pkg holds:
  - CHAR_TERM=8'd36, CHAR_SEP=8'd35, CHAR_LETTER_MIN=8'd64.
  - State encoding: IDLE, RDY, SEND, TERM, WAIT, FIN (3-bit).
  - The downstream FIFO adopts the same constants.
- Sub-module tx_byte_buf:
  - DEPTH x DATA_LEN circular buffer with wr_ptr, rd_ptr and count.
  - push/pop strobes; full/empty flags.
- The FSM and letter counting stay in checkin_tx.

Test Plan:
1. Load "A","b","3","C" (8'd65,98,51,67), then start:
   - ready=1 for exactly one cycle.
   - Next four cycles tx_data = 65,98,51,67; then 36.
   - letter_cnt=3.
   - Connected FIFO outputs 65,98,67 with valid, then done; checkin_tx pulses done one cycle after dn_done.
2. Start with empty buffer:
   - Cycle sequence: ready=1, then tx_data=36.
   - FIFO reaches done; done pulses.
   - load_ready returns to 1 in IDLE.
3. Load 18 bytes 8'd65..8'd82:
   - The first 16 are accepted, and load_ready=0 after the 16th.
   - Stream is 65..80 in order, then 36.
   - Repeat the test twice back-to-back to exercise pointer wrap.
4. Load 8'd36 and 8'd66:
   - Only 66 is stored (count=1).
   - Stream is ready, 66, 36.
5. Assert rst=0 mid-SEND (after 2 of 5 bytes):
   - Asynchronously ready=0, tx_data=0, busy=0, state IDLE.
   - After release, load_ready=1 and letter_cnt=0.
   - A new start with an empty buffer sends only 36.
6. With CHECKIN_TX_SEP_EN defined, load "A","B","C":
   - Stream is 65,35,66,35,67,36.
   - FIFO output is still 65,66,67.

Source files
------------

// File: rtl/checkin_pkg.sv
// checkin_pkg: shared character constants and state encoding for the
// check-in transmit path; the downstream FIFO uses the same constants.
package checkin_pkg;

  localparam logic [7:0] CHAR_TERM       = 8'd36;  // '$' end of stream
  localparam logic [7:0] CHAR_SEP        = 8'd35;  // '#' filler, dropped downstream
  localparam logic [7:0] CHAR_LETTER_MIN = 8'd64;  // bytes above this are kept downstream

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RDY  = 3'd1,
    ST_SEND = 3'd2,
    ST_TERM = 3'd3,
    ST_WAIT = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/tx_byte_buf.sv
// tx_byte_buf: DEPTH x DATA_LEN circular byte buffer with write/read
// pointers and an occupancy count. Push while full and pop while empty
// are ignored. clr returns the buffer to empty without touching storage.
module tx_byte_buf #(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                push,
  input  logic [DATA_LEN-1:0] push_data,
  input  logic                pop,
  output logic [DATA_LEN-1:0] rd_data,
  output logic                full,
  output logic                empty,
  output logic [CNT_W-1:0]    count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_LEN-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic                push_ok_s;
  logic                pop_ok_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign count     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array: written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and count bookkeeping with explicit wrap at DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? PTR_ZERO : wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? PTR_ZERO : rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/checkin_tx.sv
// checkin_tx: transmit side of the check-in/pickup byte stream. Buffers
// load bytes (dropping '$'), then on start emits ready, the buffered bytes
// in load order, and a '$' terminator; waits for the downstream done and
// pulses done before clearing for the next batch.
// Optional build macro CHECKIN_TX_SEP_EN: inserts a '#' cycle after every
// transmitted letter that is not the final buffered byte.
module checkin_tx
  import checkin_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  input  logic [DATA_LEN-1:0] load_data,
  output logic                load_ready,
  input  logic                start,
  output logic                busy,
  output logic                ready,
  output logic [DATA_LEN-1:0] tx_data,
  input  logic                dn_done,
  output logic                done,
  output logic [CNT_W-1:0]    letter_cnt
);

  localparam logic [DATA_LEN-1:0] TERM_B   = DATA_LEN'(CHAR_TERM);
  localparam logic [DATA_LEN-1:0] LETTER_B = DATA_LEN'(CHAR_LETTER_MIN);
  localparam logic [DATA_LEN-1:0] ZERO_B   = {DATA_LEN{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
`ifdef CHECKIN_TX_SEP_EN
  localparam logic [DATA_LEN-1:0] SEP_B    = DATA_LEN'(CHAR_SEP);
`endif

  state_t              state_r;
  state_t              state_nx;
  logic                push_s;
  logic                pop_s;
  logic                clr_s;
  logic [DATA_LEN-1:0] tx_data_s;
  logic [DATA_LEN-1:0] rd_data_s;
  logic                full_s;
  logic                empty_s;
  logic [CNT_W-1:0]    count_s;
  logic [CNT_W-1:0]    letter_cnt_r;
  logic                load_ready_s;
`ifdef CHECKIN_TX_SEP_EN
  logic                sep_r;
  logic                sep_nx;
`endif

  tx_byte_buf #(
    .DATA_LEN (DATA_LEN),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .push      (push_s),
    .push_data (load_data),
    .pop       (pop_s),
    .rd_data   (rd_data_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (count_s)
  );

  // Outputs are decoded purely from registered state and buffer contents.
  assign load_ready_s = (state_r == ST_IDLE) && !full_s;
  assign load_ready   = load_ready_s;
  assign busy         = (state_r != ST_IDLE);
  assign ready        = (state_r == ST_RDY);
  assign done         = (state_r == ST_FIN);
  assign tx_data      = tx_data_s;
  assign letter_cnt   = letter_cnt_r;

  // State register; reset abandons any batch in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

`ifdef CHECKIN_TX_SEP_EN
  // Separator-pending flag: the next SEND cycle carries '#' instead of data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sep_r <= 1'b0;
    end else begin
      sep_r <= sep_nx;
    end
  end
`endif

  // Count of stored letters, cleared when the batch completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      letter_cnt_r <= CNT_ZERO;
    end else if (clr_s) begin
      letter_cnt_r <= CNT_ZERO;
    end else if (push_s && (load_data > LETTER_B)) begin
      letter_cnt_r <= letter_cnt_r + CNT_ONE;
    end else begin
      letter_cnt_r <= letter_cnt_r;
    end
  end

  // Next-state, buffer strobes and stream byte selection.
  always_comb begin
    state_nx  = state_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    clr_s     = 1'b0;
    tx_data_s = ZERO_B;
`ifdef CHECKIN_TX_SEP_EN
    sep_nx    = sep_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // start wins over a simultaneous load; '$' is never stored
        if (start) begin
          state_nx = ST_RDY;
        end else if (load_valid && load_ready_s && (load_data != TERM_B)) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
      end
      ST_RDY: begin
        if (!empty_s) begin
          state_nx = ST_SEND;
        end else begin
          state_nx = ST_TERM;
        end
      end
      ST_SEND: begin
`ifdef CHECKIN_TX_SEP_EN
        if (sep_r) begin
          tx_data_s = SEP_B;
          sep_nx    = 1'b0;
        end else begin
          tx_data_s = rd_data_s;
          pop_s     = 1'b1;
          if (count_s == CNT_ONE) begin
            state_nx = ST_TERM;
          end else begin
            sep_nx = (rd_data_s > LETTER_B);
          end
        end
`else
        tx_data_s = rd_data_s;
        pop_s     = 1'b1;
        if (count_s == CNT_ONE) begin
          state_nx = ST_TERM;
        end else begin
          state_nx = ST_SEND;
        end
`endif
      end
      ST_TERM: begin
        tx_data_s = TERM_B;
        state_nx  = ST_WAIT;
      end
      ST_WAIT: begin
        if (dn_done) begin
          state_nx = ST_FIN;
        end else begin
          state_nx = ST_WAIT;
        end
      end
      ST_FIN: begin
        clr_s    = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_checkin_tx.sv
// tb_checkin_tx: scoreboard bench for checkin_tx. Drivers push the expected
// token stream (ready, bytes, '$', done) into a queue; a monitor process
// pops and compares each time the DUT presents ready, a non-zero byte or done.
module tb_checkin_tx;

  localparam logic [15:0] TOK_RDY  = 16'h0100;
  localparam logic [15:0] TOK_DONE = 16'h0200;
  localparam logic [15:0] TOK_TERM = 16'h0024;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'd0;
  logic       start = 1'b0;
  logic       dn_done = 1'b0;
  logic       load_ready;
  logic       busy;
  logic       ready;
  logic [7:0] tx_data;
  logic       done;
  logic [4:0] letter_cnt;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  q[$];
  bit          term_seen = 1'b0;

  checkin_tx #(.DATA_LEN(8), .DEPTH(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .ready      (ready),
    .tx_data    (tx_data),
    .dn_done    (dn_done),
    .done       (done),
    .letter_cnt (letter_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic mon_tok(input logic [15:0] tok);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL stream: got token 0x%0h expected none at %0t", tok, $time);
    end else begin
      e = exp_q.pop_front();
      if (tok !== e) begin
        n_fail++;
        $display("FAIL stream: got token 0x%0h expected 0x%0h at %0t", tok, e, $time);
      end
      if (tok == TOK_TERM) term_seen = 1'b1;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (ready !== 1'b0) mon_tok(TOK_RDY);
        if (tx_data !== 8'd0) mon_tok({8'h00, tx_data});
        if (done !== 1'b0) mon_tok(TOK_DONE);
      end
    end
  endtask

  // Expected batch: ready, the bytes (with '#' after non-final letters when
  // the separator build is active), '$', then done.
  task automatic expect_batch(input logic [7:0] bytes[$]);
    exp_q.push_back(TOK_RDY);
    for (int i = 0; i < bytes.size(); i++) begin
      exp_q.push_back({8'h00, bytes[i]});
`ifdef CHECKIN_TX_SEP_EN
      if (bytes[i] > 8'd64 && i != bytes.size() - 1) exp_q.push_back(16'h0023);
`endif
    end
    exp_q.push_back(TOK_TERM);
    exp_q.push_back(TOK_DONE);
  endtask

  task automatic load(input logic [7:0] b);
    load_valid = 1'b1;
    load_data  = b;
    @(posedge clk); #1;
    load_valid = 1'b0;
    load_data  = 8'd0;
  endtask

  task automatic run_batch(input string tag);
    term_seen = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    load_valid = 1'b0;
    load_data = 8'd0;
    check({tag, " busy"}, busy, 1);
    for (int i = 0; i < 200 && !term_seen; i++) @(posedge clk);
    #1;
    check({tag, " term_seen"}, term_seen, 1);
    dn_done = 1'b1;
    @(posedge clk); #1;
    dn_done = 1'b0;
    check({tag, " done_pulse"}, done, 1);
    @(posedge clk); #1;
    check({tag, " done_cleared"}, done, 0);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " idle_load_ready"}, load_ready, 1);
    check({tag, " idle_letter_cnt"}, letter_cnt, 0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    #12;
    check("rst load_ready", load_ready, 1);
    check("rst ready", ready, 0);
    check("rst tx_data", tx_data, 0);
    check("rst done", done, 0);
    check("rst busy", busy, 0);
    check("rst letter_cnt", letter_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: "A","b","3","C"
    load(8'd65); load(8'd98); load(8'd51); load(8'd67);
    check("t1 letter_cnt", letter_cnt, 3);
    q = '{8'd65, 8'd98, 8'd51, 8'd67};
    expect_batch(q);
    run_batch("t1");

    // 2: empty buffer; a simultaneous load must lose to start
    q = {};
    expect_batch(q);
    load_valid = 1'b1;
    load_data  = 8'd80;
    run_batch("t2");

    // 3: overfill with 18 bytes, twice for pointer wrap
    for (int r = 0; r < 2; r++) begin
      q = {};
      for (int i = 0; i < 18; i++) begin
        check("t3 load_ready", load_ready, (i < 16) ? 1 : 0);
        load(8'(65 + i));
        if (i < 16) q.push_back(8'(65 + i));
      end
      check("t3 full_load_ready", load_ready, 0);
      check("t3 letter_cnt", letter_cnt, 16);
      expect_batch(q);
      run_batch("t3");
    end

    // 4: '$' is dropped on load
    load(8'd36); load(8'd66);
    check("t4 letter_cnt", letter_cnt, 1);
    q = '{8'd66};
    expect_batch(q);
    run_batch("t4");

    // 5: reset after two of five bytes are on the bus
    load(8'd49); load(8'd50); load(8'd51); load(8'd52); load(8'd90);
    check("t5 letter_cnt", letter_cnt, 1);
    exp_q.push_back(TOK_RDY);
    exp_q.push_back(16'd49);
    exp_q.push_back(16'd50);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("t5 rst ready", ready, 0);
    check("t5 rst tx_data", tx_data, 0);
    check("t5 rst busy", busy, 0);
    check("t5 rst done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("t5 load_ready", load_ready, 1);
    check("t5 letter_cnt", letter_cnt, 0);
    check("t5 partial_drained", exp_q.size(), 0);
    q = {};
    expect_batch(q);
    run_batch("t5b");

    // 6: "A","B","C" (separators appear only in the separator build)
    load(8'd65); load(8'd66); load(8'd67);
    check("t6 letter_cnt", letter_cnt, 3);
    q = '{8'd65, 8'd66, 8'd67};
    expect_batch(q);
    run_batch("t6");

    repeat (3) @(posedge clk);
    check("end queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
